// File: rtl/lm32_dtlb_refill.sv
// lm32_dtlb_refill: hardware DTLB refill engine, fetches one PTE over a Wishbone
// classic read and emits either a DTLB write strobe or a fault strobe.
module lm32_dtlb_refill #(
    parameter int page_size = 4096,
    parameter int timeout   = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable,
    input  logic        start_i,
    input  logic [31:0] miss_addr_i,
    input  logic [31:0] ptbr_i,
    input  logic        abort_i,
    output logic [31:0] wb_adr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy_o,
    output logic        tlb_write_o,
    output logic [31:0] tlb_vaddr_o,
    output logic [31:0] tlb_paddr_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o
);
    localparam int OFS = $clog2(page_size);
    localparam int PW  = 32 - OFS;

    typedef enum logic [1:0] {IDLE, REQ, WRITE, FAULT} state_t;

    state_t        state;
    logic [PW-1:0] vpfn;
    logic [PW-1:0] pfn;
    logic [15:0]   timer;
    logic [1:0]    cause;
    logic          unused_bits;

    assign unused_bits = ^{wb_dat_i[OFS-1:1], ptbr_i[1:0], miss_addr_i[OFS-1:0]};

    // The strobe is issued on the edge leaving WRITE/FAULT so an abort seen in
    // that state can still suppress it; busy_o covers the strobe cycle too.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            vpfn          <= '0;
            pfn           <= '0;
            timer         <= '0;
            cause         <= 2'b00;
            wb_adr_o      <= '0;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            busy_o        <= 1'b0;
            tlb_write_o   <= 1'b0;
            tlb_vaddr_o   <= '0;
            tlb_paddr_o   <= '0;
            fault_o       <= 1'b0;
            fault_cause_o <= 2'b00;
        end else begin
            tlb_write_o <= 1'b0;
            fault_o     <= 1'b0;
            case (state)
                IDLE: begin
                    busy_o <= 1'b0;
                    if (enable && start_i && !abort_i && !busy_o) begin
                        vpfn          <= miss_addr_i[31:OFS];
                        wb_adr_o      <= {ptbr_i[31:2], 2'b00} + {{(OFS-2){1'b0}}, miss_addr_i[31:OFS], 2'b00};
                        wb_cyc_o      <= 1'b1;
                        wb_stb_o      <= 1'b1;
                        busy_o        <= 1'b1;
                        timer         <= '0;
                        fault_cause_o <= 2'b00;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (abort_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        busy_o   <= 1'b0;
                        state    <= IDLE;
                    end else if (wb_err_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        cause    <= 2'b10;
                        state    <= FAULT;
                    end else if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        pfn      <= wb_dat_i[31:OFS];
                        cause    <= 2'b01;
                        state    <= wb_dat_i[0] ? WRITE : FAULT;
                    end else if (timer == 16'(timeout - 1)) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        cause    <= 2'b11;
                        state    <= FAULT;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                WRITE: begin
                    busy_o      <= !abort_i;
                    tlb_write_o <= !abort_i;
                    tlb_vaddr_o <= {vpfn, {OFS{1'b0}}};
                    tlb_paddr_o <= {pfn, {OFS{1'b0}}};
                    state       <= IDLE;
                end
                FAULT: begin
                    busy_o  <= !abort_i;
                    fault_o <= !abort_i;
                    if (!abort_i)
                        fault_cause_o <= cause;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
